// File: rtl/or1200_alarm_agg_if.sv
// Checker-to-CPU alarm bus for or1200_alarm_agg.
// The master side drives the checker results and the clear request.
// The slave side (the aggregator) returns the alarm status.
interface or1200_alarm_agg_if #(
  parameter int NCHK = 7
);
  logic [NCHK-1:0] chk_ok;
  logic [NCHK-1:0] chk_en;
  logic            clr_req;
  logic            clr_ack;
  logic            alarm;
  logic            alarm_pulse;
  logic [NCHK-1:0] fault_vec;
  logic [4:0]      first_idx;
  logic [7:0]      fault_cnt;

  modport master (
    output chk_ok, chk_en, clr_req,
    input  clr_ack, alarm, alarm_pulse, fault_vec, first_idx, fault_cnt
  );

  modport slave (
    input  chk_ok, chk_en, clr_req,
    output clr_ack, alarm, alarm_pulse, fault_vec, first_idx, fault_cnt
  );
endinterface

// File: rtl/or1200_alarm_agg.sv
// Alarm aggregator: per-channel persistence filters feed either a latched
// alarm FSM with a clear handshake (STICKY=1) or a plain registered
// pass-through (STICKY=0). Every output comes straight from a flop.
module or1200_alarm_agg #(
  parameter int NCHK    = 7,
  parameter int PERSIST = 2,
  parameter int STICKY  = 1
) (
  input logic                   clk,
  input logic                   rst,
  or1200_alarm_agg_if.slave     bus
);
  typedef enum logic [1:0] {ARMED, ALARM, CLEAR} state_t;

  localparam logic [3:0] PMAX = 4'(PERSIST);
  localparam logic [3:0] TLIM = 4'(PERSIST - 1);

  state_t                     state_q, state_d;
  logic [NCHK-1:0][3:0]       cnt_q, cnt_d, cnt_inc;
  logic [NCHK-1:0]            trip;
  logic                       any_trip;
  logic                       alarm_q, alarm_d;
  logic                       pulse_q, pulse_d;
  logic                       ack_q, ack_d;
  logic [NCHK-1:0]            fvec_q, fvec_d;
  logic [4:0]                 fidx_q, fidx_d;
  logic [7:0]                 fcnt_q, fcnt_d;
  logic [7:0]                 fcnt_sat;

  // Lowest set index; 0 when the vector is empty.
  function automatic logic [4:0] low_idx(input logic [NCHK-1:0] v);
    low_idx = '0;
    for (int i = NCHK - 1; i >= 0; i--)
      if (v[i]) low_idx = 5'(i);
  endfunction

  // Persistence filter: count consecutive enabled failures, trip on the PERSIST-th.
  always_comb begin
    trip    = '0;
    cnt_inc = '0;
    for (int i = 0; i < NCHK; i++) begin
      if (bus.chk_en[i] && !bus.chk_ok[i]) begin
        trip[i]    = (cnt_q[i] >= TLIM);
        cnt_inc[i] = (cnt_q[i] == PMAX) ? PMAX : 4'(cnt_q[i] + 4'd1);
      end
    end
  end

  assign any_trip = |trip;
  assign fcnt_sat = (fcnt_q == 8'hFF) ? fcnt_q : 8'(fcnt_q + 8'd1);

  // Next-state and output decode for both the latched FSM and pass-through modes.
  always_comb begin
    state_d = state_q;
    alarm_d = alarm_q;
    pulse_d = 1'b0;
    ack_d   = 1'b0;
    fvec_d  = fvec_q;
    fidx_d  = fidx_q;
    fcnt_d  = fcnt_q;
    cnt_d   = cnt_inc;
    if (STICKY != 0) begin
      case (state_q)
        ARMED: begin
          // A trip beats a coincident clear request.
          if (any_trip) begin
            state_d = ALARM;
            alarm_d = 1'b1;
            pulse_d = 1'b1;
            fvec_d  = trip;
            fidx_d  = low_idx(trip);
            fcnt_d  = fcnt_sat;
          end else begin
            ack_d = bus.clr_req;
          end
        end
        ALARM: begin
          fvec_d = fvec_q | trip;
          // Clear is held off while any channel is still tripping.
          if (bus.clr_req && !any_trip) begin
            state_d = CLEAR;
            alarm_d = 1'b0;
            ack_d   = 1'b1;
            fvec_d  = '0;
            fidx_d  = '0;
            cnt_d   = '0;
          end
        end
        CLEAR: begin
          // Failures seen during the clear cycle are discarded.
          state_d = ARMED;
          ack_d   = bus.clr_req;
          cnt_d   = '0;
        end
        default: state_d = ARMED;
      endcase
    end else begin
      alarm_d = any_trip;
      pulse_d = any_trip && !alarm_q;
      fvec_d  = trip;
      fidx_d  = low_idx(trip);
      ack_d   = bus.clr_req;
      if (pulse_d) fcnt_d = fcnt_sat;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMED;
      cnt_q   <= '0;
      alarm_q <= 1'b0;
      pulse_q <= 1'b0;
      ack_q   <= 1'b0;
      fvec_q  <= '0;
      fidx_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alarm_q <= alarm_d;
      pulse_q <= pulse_d;
      ack_q   <= ack_d;
      fvec_q  <= fvec_d;
      fidx_q  <= fidx_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.alarm       = alarm_q;
  assign bus.alarm_pulse = pulse_q;
  assign bus.clr_ack     = ack_q;
  assign bus.fault_vec   = fvec_q;
  assign bus.first_idx   = fidx_q;
  assign bus.fault_cnt   = fcnt_q;
endmodule

// File: tb/tb_or1200_alarm_agg.sv
// Bench for or1200_alarm_agg: a latched instance and a pass-through instance
// share one stimulus stream; a behavioural model checks both every cycle,
// and directed literal checks pin the model's key scenarios.
module tb_or1200_alarm_agg;
  localparam int NCHK    = 7;
  localparam int PERSIST = 2;

  logic            clk;
  logic            rst_v;
  logic [NCHK-1:0] ok_v, en_v;
  logic            clr_v;
  logic            done;
  int              n_cmp, n_bad;

  or1200_alarm_agg_if #(.NCHK(NCHK)) ifs ();
  or1200_alarm_agg_if #(.NCHK(NCHK)) ifp ();

  assign ifs.chk_ok  = ok_v;
  assign ifs.chk_en  = en_v;
  assign ifs.clr_req = clr_v;
  assign ifp.chk_ok  = ok_v;
  assign ifp.chk_en  = en_v;
  assign ifp.clr_req = clr_v;

  or1200_alarm_agg #(.NCHK(NCHK), .PERSIST(PERSIST), .STICKY(1)) u_s (
    .clk(clk), .rst(rst_v), .bus(ifs)
  );
  or1200_alarm_agg #(.NCHK(NCHK), .PERSIST(PERSIST), .STICKY(0)) u_p (
    .clk(clk), .rst(rst_v), .bus(ifp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         runs[NCHK], runp[NCHK];   // consecutive enabled failures seen so far
  bit         ms_latched, ms_clearing;
  bit         ms_alarm, ms_pulse, ms_ack;
  bit [NCHK-1:0] ms_fvec;
  int         ms_fidx, ms_fcnt;
  bit         mp_alarm, mp_pulse, mp_ack;
  bit [NCHK-1:0] mp_fvec;
  int         mp_fidx, mp_fcnt;

  function automatic int lowest(input bit [NCHK-1:0] v);
    for (int i = 0; i < NCHK; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clk) begin : model
    bit [NCHK-1:0] fl, tv, tp;
    bit zr;
    fl = en_v & ~ok_v;
    for (int i = 0; i < NCHK; i++) begin
      tv[i] = fl[i] && (runs[i] >= PERSIST - 1);
      tp[i] = fl[i] && (runp[i] >= PERSIST - 1);
    end
    if (rst_v) begin
      ms_latched <= 0; ms_clearing <= 0; ms_alarm <= 0; ms_pulse <= 0; ms_ack <= 0;
      ms_fvec <= '0; ms_fidx <= 0; ms_fcnt <= 0;
      mp_alarm <= 0; mp_pulse <= 0; mp_ack <= 0; mp_fvec <= '0; mp_fidx <= 0; mp_fcnt <= 0;
      for (int i = 0; i < NCHK; i++) begin runs[i] <= 0; runp[i] <= 0; end
    end else begin
      zr = 0;
      ms_pulse <= 0;
      ms_ack   <= 0;
      if (ms_clearing) begin
        ms_clearing <= 0;
        ms_ack      <= clr_v;
        zr          = 1;
      end else if (!ms_latched) begin
        if (tv != 0) begin
          ms_latched <= 1; ms_alarm <= 1; ms_pulse <= 1;
          ms_fvec <= tv; ms_fidx <= lowest(tv);
          ms_fcnt <= (ms_fcnt >= 255) ? 255 : ms_fcnt + 1;
        end else ms_ack <= clr_v;
      end else begin
        if (clr_v && tv == 0) begin
          ms_latched <= 0; ms_clearing <= 1; ms_alarm <= 0; ms_ack <= 1;
          ms_fvec <= '0; ms_fidx <= 0; zr = 1;
        end else ms_fvec <= ms_fvec | tv;
      end
      for (int i = 0; i < NCHK; i++) begin
        runs[i] <= (zr || !fl[i]) ? 0 : runs[i] + 1;
        runp[i] <= fl[i] ? runp[i] + 1 : 0;
      end
      mp_alarm <= (tp != 0);
      mp_pulse <= (tp != 0) && !mp_alarm;
      mp_fvec  <= tp;
      mp_fidx  <= lowest(tp);
      mp_ack   <= clr_v;
      if ((tp != 0) && !mp_alarm && mp_fcnt < 255) mp_fcnt <= mp_fcnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!done) begin
        chk("s.alarm", 32'(ifs.alarm), 32'(ms_alarm));
        chk("s.pulse", 32'(ifs.alarm_pulse), 32'(ms_pulse));
        chk("s.ack",   32'(ifs.clr_ack), 32'(ms_ack));
        chk("s.fvec",  32'(ifs.fault_vec), 32'(ms_fvec));
        chk("s.fidx",  32'(ifs.first_idx), 32'(ms_fidx));
        chk("s.fcnt",  32'(ifs.fault_cnt), 32'(ms_fcnt));
        chk("p.alarm", 32'(ifp.alarm), 32'(mp_alarm));
        chk("p.pulse", 32'(ifp.alarm_pulse), 32'(mp_pulse));
        chk("p.ack",   32'(ifp.clr_ack), 32'(mp_ack));
        chk("p.fvec",  32'(ifp.fault_vec), 32'(mp_fvec));
        chk("p.fidx",  32'(ifp.first_idx), 32'(mp_fidx));
        chk("p.fcnt",  32'(ifp.fault_cnt), 32'(mp_fcnt));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int na, np;
    n_cmp = 0; n_bad = 0; done = 1'b0;
    rst_v = 1'b1; ok_v = '1; en_v = '1; clr_v = 1'b0;
    step(2);
    chk("rst.alarm", 32'(ifs.alarm), 32'd0);
    chk("rst.fcnt",  32'(ifs.fault_cnt), 32'd0);
    chk("rst.fvec",  32'(ifs.fault_vec), 32'd0);
    rst_v = 1'b0;
    step(1);

    // single failing sample does not trip
    ok_v = 7'h77; step(1);
    ok_v = 7'h7F; step(2);
    chk("one.alarm", 32'(ifs.alarm), 32'd0);
    chk("one.fcnt",  32'(ifs.fault_cnt), 32'd0);

    // two failing samples on channel 3
    ok_v = 7'h77; step(2);
    chk("two.alarm", 32'(ifs.alarm), 32'd1);
    chk("two.pulse", 32'(ifs.alarm_pulse), 32'd1);
    chk("two.fvec",  32'(ifs.fault_vec), 32'h08);
    chk("two.fidx",  32'(ifs.first_idx), 32'd3);
    chk("two.fcnt",  32'(ifs.fault_cnt), 32'd1);
    step(1);
    chk("two.pulse_off", 32'(ifs.alarm_pulse), 32'd0);

    // clear held off while channel 3 still fails
    clr_v = 1'b1; step(2);
    chk("hold.ack",   32'(ifs.clr_ack), 32'd0);
    chk("hold.alarm", 32'(ifs.alarm), 32'd1);
    ok_v = 7'h7F; step(1);
    chk("clr.ack",   32'(ifs.clr_ack), 32'd1);
    chk("clr.alarm", 32'(ifs.alarm), 32'd0);
    chk("clr.fvec",  32'(ifs.fault_vec), 32'd0);
    chk("clr.fcnt",  32'(ifs.fault_cnt), 32'd1);
    clr_v = 1'b0; step(1);
    chk("clr.ack_off", 32'(ifs.clr_ack), 32'd0);

    // clear request while armed: bare ack
    clr_v = 1'b1; step(1);
    chk("armed.ack", 32'(ifs.clr_ack), 32'd1);
    clr_v = 1'b0; step(1);
    chk("armed.ack_off", 32'(ifs.clr_ack), 32'd0);
    chk("armed.alarm",   32'(ifs.alarm), 32'd0);

    // simultaneous trips on channels 5 and 1 after a fresh reset
    rst_v = 1'b1; step(1);
    rst_v = 1'b0; ok_v = 7'h5D; step(2);
    chk("dual.fidx", 32'(ifs.first_idx), 32'd1);
    chk("dual.fvec", 32'(ifs.fault_vec), 32'h22);
    chk("dual.fcnt", 32'(ifs.fault_cnt), 32'd1);
    ok_v = 7'h7F; clr_v = 1'b1; step(1);
    clr_v = 1'b0; step(1);

    // disabled failing channel never trips; enabling it trips 2 cycles later
    ok_v = 7'h7B; en_v = 7'h7B; step(10);
    chk("dis.alarm", 32'(ifs.alarm), 32'd0);
    en_v = 7'h7F; step(1);
    chk("en1.alarm", 32'(ifs.alarm), 32'd0);
    step(1);
    chk("en2.alarm", 32'(ifs.alarm), 32'd1);
    chk("en2.fvec",  32'(ifs.fault_vec), 32'h04);
    chk("en2.fidx",  32'(ifs.first_idx), 32'd2);
    chk("en2.fcnt",  32'(ifs.fault_cnt), 32'd2);
    ok_v = 7'h7F; clr_v = 1'b1; step(1);
    clr_v = 1'b0; step(1);

    // third alarm entry, then reset mid-alarm
    ok_v = 7'h7E; step(2);
    chk("third.fcnt",  32'(ifs.fault_cnt), 32'd3);
    chk("third.alarm", 32'(ifs.alarm), 32'd1);
    rst_v = 1'b1; ok_v = 7'h7F; step(1);
    chk("mid.alarm", 32'(ifs.alarm), 32'd0);
    chk("mid.pulse", 32'(ifs.alarm_pulse), 32'd0);
    chk("mid.ack",   32'(ifs.clr_ack), 32'd0);
    chk("mid.fvec",  32'(ifs.fault_vec), 32'd0);
    chk("mid.fidx",  32'(ifs.first_idx), 32'd0);
    chk("mid.fcnt",  32'(ifs.fault_cnt), 32'd0);
    rst_v = 1'b0; ok_v = 7'h7E; step(1);
    chk("restart.alarm0", 32'(ifs.alarm), 32'd0);
    step(1);
    chk("restart.alarm1", 32'(ifs.alarm), 32'd1);
    ok_v = 7'h7F; rst_v = 1'b1; step(1);
    rst_v = 1'b0; step(1);

    // pass-through: 3-cycle failure gives exactly 2 alarm cycles and one pulse
    na = 0; np = 0;
    ok_v = 7'h77;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (ifp.alarm) na++;
      if (ifp.alarm_pulse) np++;
      if (k == 3) ok_v = 7'h7F;
    end
    chk("pass.alarm_cycles", 32'(na), 32'd2);
    chk("pass.pulses",       32'(np), 32'd1);
    chk("pass.fcnt",         32'(ifp.fault_cnt), 32'd1);

    // pass-through clear ack is the registered request
    clr_v = 1'b1; step(1);
    chk("pass.ack", 32'(ifp.clr_ack), 32'd1);
    clr_v = 1'b0; step(2);

    done = 1'b1;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
